uart_tx_buffered: RTL and testbench
===================================

UART_TX_BUFFERED -- requirements
Module: uart_tx_buffered

Interface
REQ-001 The block SHALL have parameter DATA_BITS, default 8, payload bits per frame; legal range 5..8.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, transmit FIFO entries; power of two, >= 2.
REQ-003 The block SHALL have parameter DIV_WIDTH, default 16, width of the baud divisor input.
REQ-004 The block SHALL have port clk, input, 1, the single system clock; all logic rising-edge.
REQ-005 The block SHALL have port resetn, input, 1, reset, asynchronous and active-low.
REQ-006 The block SHALL have port cfg_div, input, DIV_WIDTH, bit period minus one, in clk cycles.
REQ-007 The block SHALL have port cfg_parity, input, 2, parity mode: 00 none, 01 even, 10 odd, 11 none.
REQ-008 The block SHALL have port cfg_stop2, input, 1, stop bits: 0 selects one, 1 selects two.
REQ-009 The block SHALL have port tx_valid, input, 1, a write request.
REQ-010 The block SHALL have port tx_data, input, DATA_BITS, the payload to queue.
REQ-011 The block SHALL have port tx_ready, output, 1, FIFO not full.
REQ-012 The block SHALL have port uart_txd, output, 1, serial line, registered, idle high.
REQ-013 The block SHALL have port uart_tx_busy, output, 1, high when a frame is in flight or the FIFO is non-empty.
REQ-014 The block SHALL have port fifo_level, output, $clog2(FIFO_DEPTH)+1, current FIFO occupancy.

Function
REQ-015 A FIFO write SHALL occur on any cycle with tx_valid && tx_ready; tx_ready SHALL equal (fifo_level != FIFO_DEPTH).
REQ-016 The FSM SHALL use states IDLE, START, DATA, PARITY, STOP.
REQ-017 In IDLE with the FIFO non-empty (registered level), the FSM SHALL pop one entry, latch cfg_div/cfg_parity/cfg_stop2, and enter START next cycle.
REQ-018 Configuration inputs SHALL affect only frames started after they change; the latched values SHALL hold for the whole frame.
REQ-019 Each line bit SHALL last exactly cfg_div+1 clk cycles; cfg_div=0 SHALL give 1-cycle bits.
REQ-020 Frame order SHALL be: start (0), DATA_BITS data bits LSB first, parity bit if enabled, then 1 or 2 stop bits (1).
REQ-021 The parity bit SHALL be the XOR of the payload for even mode and its inverse for odd mode.
REQ-022 uart_txd SHALL go low on the cycle after the pop; with an empty idle block, a write in cycle N SHALL produce a start bit from cycle N+2.
REQ-023 If the FIFO is non-empty in the last cycle of the final stop bit, the pop SHALL occur in that cycle and the next start bit SHALL follow with zero idle cycles.
REQ-024 A simultaneous write and pop SHALL leave fifo_level unchanged; FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-025 A write attempted while full SHALL be dropped without corrupting FIFO contents.
REQ-026 uart_tx_busy SHALL be low only in IDLE with fifo_level == 0.

Reset
REQ-027 While resetn is low, the block SHALL force uart_txd=1, uart_tx_busy=0, fifo_level=0, tx_ready=1, and FSM=IDLE, independent of clk.
REQ-028 Reset asserted mid-frame SHALL abandon the frame and discard FIFO contents; no partial frame SHALL resume after release.
REQ-029 tx_valid SHALL be ignored while resetn is low.

Verification
REQ-030 With DATA_BITS=8, cfg_div=3, parity none, one stop bit, writing 0xA5 SHALL produce txd 0,1,0,1,0,0,1,0,1,1, each held for 4 cycles, with start at write+2.
REQ-031 Repeating REQ-030 with even parity SHALL insert parity bit 0 before stop, and with odd parity SHALL insert parity bit 1; cfg_stop2=1 SHALL give an 8-cycle high stop.
REQ-032 With FIFO_DEPTH=4, writing 6 bytes back-to-back SHALL show tx_ready low at level 4 and the 6th write held until a pop, with all 6 frames sent with no idle gap between them.
REQ-033 Changing cfg_div from 3 to 7 mid-frame SHALL leave the current frame at 4 cycles per bit and make the next frame 8 cycles per bit.
REQ-034 Pulsing resetn low during data bit 3 SHALL force txd=1 and fifo_level=0 immediately; after release, txd SHALL stay high until a new write.
REQ-035 A write while full, with no pop in the same cycle, SHALL leave fifo_level=4 and the transmitted byte sequence unchanged.

Source files
------------

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: a small FIFO feeding a start/data/parity/stop serializer.
// Each frame uses the baud divisor, parity mode and stop-bit count captured when it is popped.
module uart_tx_buffered #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [DIV_WIDTH-1:0]          cfg_div,
    input  logic [1:0]                    cfg_parity,
    input  logic                          cfg_stop2,
    input  logic                          tx_valid,
    input  logic [DATA_BITS-1:0]          tx_data,
    output logic                          tx_ready,
    output logic                          uart_txd,
    output logic                          uart_tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // ---------------- FIFO ----------------
    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [LW-1:0]        r_level;
    logic [DATA_BITS-1:0] w_rd_data;
    logic                 w_push;
    logic                 w_pop;

    assign tx_ready   = (r_level != FULL_LVL);
    assign fifo_level = r_level;
    assign w_push     = tx_valid && tx_ready;
    assign w_rd_data  = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= tx_data;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // ---------------- Serializer ----------------
    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_txd;
    logic                 w_txd_nxt;
    logic [DIV_WIDTH-1:0] r_div;
    logic [DIV_WIDTH-1:0] r_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic [BW-1:0]        r_bit_idx;
    logic                 r_par_en;
    logic                 r_par;
    logic                 r_stop2;
    logic                 r_stop_idx;
    logic                 w_bit_end;
    logic                 w_fifo_ne;

    assign w_bit_end    = (r_cnt == '0);
    assign w_fifo_ne    = (r_level != '0);
    assign uart_txd     = r_txd;
    assign uart_tx_busy = (r_state != S_IDLE) || w_fifo_ne;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_txd_nxt   = r_txd;
        case (r_state)
            S_IDLE: begin
                w_txd_nxt = 1'b1;
                if (w_fifo_ne) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_START;
                    w_txd_nxt   = 1'b0;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_nxt = S_DATA;
                    w_txd_nxt   = r_shift[0];
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    if (r_bit_idx == LAST_BIT) begin
                        if (r_par_en) begin
                            w_state_nxt = S_PARITY;
                            w_txd_nxt   = r_par;
                        end else begin
                            w_state_nxt = S_STOP;
                            w_txd_nxt   = 1'b1;
                        end
                    end else begin
                        w_txd_nxt = r_shift[1];
                    end
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    w_state_nxt = S_STOP;
                    w_txd_nxt   = 1'b1;
                end
            end
            S_STOP: begin
                if (w_bit_end && (!r_stop2 || r_stop_idx)) begin
                    // Back-to-back frames: pop in the final stop cycle, no idle gap.
                    if (w_fifo_ne) begin
                        w_pop       = 1'b1;
                        w_state_nxt = S_START;
                        w_txd_nxt   = 1'b0;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_txd_nxt   = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_txd_nxt   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_txd      <= 1'b1;
            r_div      <= '0;
            r_cnt      <= '0;
            r_shift    <= '0;
            r_bit_idx  <= '0;
            r_par_en   <= 1'b0;
            r_par      <= 1'b0;
            r_stop2    <= 1'b0;
            r_stop_idx <= 1'b0;
        end else begin
            r_txd <= w_txd_nxt;
            if (w_pop) begin
                r_div      <= cfg_div;
                r_cnt      <= cfg_div;
                r_shift    <= w_rd_data;
                r_bit_idx  <= '0;
                r_par_en   <= cfg_parity[0] ^ cfg_parity[1];
                r_par      <= (^w_rd_data) ^ cfg_parity[1];
                r_stop2    <= cfg_stop2;
                r_stop_idx <= 1'b0;
            end else if (r_state != S_IDLE) begin
                if (w_bit_end) begin
                    r_cnt <= r_div;
                    if (r_state == S_DATA) begin
                        r_shift   <= r_shift >> 1;
                        r_bit_idx <= r_bit_idx + BW'(1);
                    end
                    if (r_state == S_STOP) begin
                        r_stop_idx <= 1'b1;
                    end
                end else begin
                    r_cnt <= r_cnt - DIV_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered: frame shapes, parity/stop options, FIFO fill,
// mid-frame divisor change and mid-frame reset, all against hand-derived line patterns.
module tb_uart_tx_buffered;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int DIVW  = 16;

    logic            clk = 1'b0;
    logic            resetn;
    logic [DIVW-1:0] cfg_div;
    logic [1:0]      cfg_parity;
    logic            cfg_stop2;
    logic            tx_valid;
    logic [DW-1:0]   tx_data;
    logic            tx_ready;
    logic            uart_txd;
    logic            uart_tx_busy;
    logic [2:0]      fifo_level;

    int n_checks = 0;
    int n_errors = 0;

    uart_tx_buffered #(.DATA_BITS(DW), .FIFO_DEPTH(DEPTH), .DIV_WIDTH(DIVW)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .cfg_div      (cfg_div),
        .cfg_parity   (cfg_parity),
        .cfg_stop2    (cfg_stop2),
        .tx_valid     (tx_valid),
        .tx_data      (tx_data),
        .tx_ready     (tx_ready),
        .uart_txd     (uart_txd),
        .uart_tx_busy (uart_tx_busy),
        .fifo_level   (fifo_level)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // bits[0] is the first line bit (start); each bit must hold for exactly per cycles.
    task automatic check_frame(input string tag, input logic [15:0] bits, input int n, input int per);
        for (int i = 0; i < n; i++) begin
            logic obs;
            obs = bits[i];
            for (int c = 0; c < per; c++) begin
                if (uart_txd !== bits[i]) obs = uart_txd;
                tick();
            end
            check_val($sformatf("%s_b%0d", tag, i), {31'b0, obs}, {31'b0, bits[i]});
        end
    endtask

    task automatic wait_start(input int max);
        int k;
        k = 0;
        while (uart_txd !== 1'b0 && k < max) begin
            tick();
            k++;
        end
        check_val("start_seen", {31'b0, uart_txd === 1'b0}, 32'd1);
    endtask

    task automatic write_one(input logic [7:0] d);
        tx_valid = 1'b1;
        tx_data  = d;
        tick();
        tx_valid = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check_val({tag, "_txd"},   {31'b0, uart_txd},     32'd1);
        check_val({tag, "_busy"},  {31'b0, uart_tx_busy}, 32'd0);
        check_val({tag, "_level"}, {29'b0, fifo_level},   32'd0);
    endtask

    function automatic logic [15:0] plain_frame(input logic [7:0] d);
        return {6'b0, 1'b1, d, 1'b0};
    endfunction

    logic [7:0] fill_data [6];
    logic       saw_full;
    int         lows;

    initial begin
        fill_data = '{8'h3C, 8'hFF, 8'h00, 8'h81, 8'h5A, 8'hC3};
        resetn     = 1'b0;
        tx_valid   = 1'b1;
        tx_data    = 8'h77;
        cfg_div    = 16'd3;
        cfg_parity = 2'b00;
        cfg_stop2  = 1'b0;
        saw_full   = 1'b0;

        // Reset state, with a write request held during reset.
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_txd",   {31'b0, uart_txd},     32'd1);
        check_val("rst_busy",  {31'b0, uart_tx_busy}, 32'd0);
        check_val("rst_level", {29'b0, fifo_level},   32'd0);
        check_val("rst_ready", {31'b0, tx_ready},     32'd1);
        tx_valid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        tick();
        tick();
        check_idle("post_rst");

        // 0xA5, 4 cycles/bit, no parity, one stop: start exactly two cycles after the write.
        tx_valid = 1'b1;
        tx_data  = 8'hA5;
        tick();
        tx_valid = 1'b0;
        check_val("pre_start_txd", {31'b0, uart_txd},   32'd1);
        check_val("level_one",     {29'b0, fifo_level}, 32'd1);
        tick();
        check_val("level_after_pop", {29'b0, fifo_level},   32'd0);
        check_val("busy_in_frame",   {31'b0, uart_tx_busy}, 32'd1);
        check_frame("a5_none", 16'h034A, 10, 4);
        check_idle("a5_none_end");

        cfg_parity = 2'b01;
        write_one(8'hA5);
        tick();
        check_frame("a5_even", 16'h054A, 11, 4);
        check_idle("a5_even_end");

        cfg_parity = 2'b10;
        write_one(8'hA5);
        tick();
        check_frame("a5_odd", 16'h074A, 11, 4);
        check_idle("a5_odd_end");

        cfg_parity = 2'b00;
        cfg_stop2  = 1'b1;
        write_one(8'hA5);
        tick();
        check_frame("a5_stop2", 16'h074A, 11, 4);
        check_idle("a5_stop2_end");
        cfg_stop2 = 1'b0;

        // Parity mode 11 is "none"; divisor 0 gives single-cycle bits.
        cfg_parity = 2'b11;
        cfg_div    = 16'd0;
        write_one(8'h0F);
        tick();
        check_frame("div0_par11", plain_frame(8'h0F), 10, 1);
        check_idle("div0_end");
        cfg_parity = 2'b00;

        // Divisor change mid-frame only affects the following frame.
        cfg_div  = 16'd3;
        tx_valid = 1'b1;
        tx_data  = 8'h0F;
        tick();
        tx_data  = 8'hF0;
        tick();
        tx_valid = 1'b0;
        fork
            begin
                check_frame("div_old", plain_frame(8'h0F), 10, 4);
                check_frame("div_new", plain_frame(8'hF0), 10, 8);
            end
            begin
                repeat (6) tick();
                cfg_div = 16'd7;
            end
        join
        check_idle("div_chg_end");

        // Six back-to-back writes into a 4-deep FIFO; junk offered while full must be dropped.
        cfg_div = 16'd1;
        fork
            begin
                for (int k = 0; k < 6; k++) begin
                    int g;
                    g = 0;
                    tx_valid = 1'b1;
                    while (tx_ready !== 1'b1 && g < 200) begin
                        tx_data = 8'hEE;
                        if (!saw_full) check_val("full_level", {29'b0, fifo_level}, 32'd4);
                        saw_full = 1'b1;
                        tick();
                        g++;
                    end
                    tx_data = fill_data[k];
                    tick();
                end
                tx_valid = 1'b0;
            end
            begin
                wait_start(20);
                for (int k = 0; k < 6; k++) begin
                    check_frame($sformatf("fill%0d", k), plain_frame(fill_data[k]), 10, 2);
                end
            end
        join
        check_val("saw_full", {31'b0, saw_full}, 32'd1);
        check_idle("fill_end");

        // Reset during data bit 3 abandons the frame and the queued byte.
        cfg_div  = 16'd3;
        tx_valid = 1'b1;
        tx_data  = 8'hA5;
        tick();
        tx_data  = 8'h3C;
        tick();
        tx_valid = 1'b0;
        repeat (17) tick();
        check_val("pre_rst_bit3", {31'b0, uart_txd}, 32'd0);
        #2;
        resetn = 1'b0;
        #1;
        check_val("mid_rst_txd",   {31'b0, uart_txd},     32'd1);
        check_val("mid_rst_level", {29'b0, fifo_level},   32'd0);
        check_val("mid_rst_busy",  {31'b0, uart_tx_busy}, 32'd0);
        check_val("mid_rst_ready", {31'b0, tx_ready},     32'd1);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        tick();
        lows = 0;
        for (int c = 0; c < 60; c++) begin
            if (uart_txd !== 1'b1) lows++;
            tick();
        end
        check_val("post_rst_lows", lows, 32'd0);
        check_idle("post_mid_rst");
        write_one(8'h3C);
        tick();
        check_frame("after_rst", plain_frame(8'h3C), 10, 4);
        check_idle("final");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
